// File: rtl/cache_way_fill.sv
// Fill-side way selector for a 4-way set-associative cache: it picks the victim way and
// broadcasts the line one cycle after the handshake. It tracks way-valid bits and a tree PLRU per set.
module cache_way_fill #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int SET_IDX_W       = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_fill_valid,
  output logic                         o_fill_ready,
  input  logic [SET_IDX_W-1:0]         i_fill_set,
  input  logic [LINE_SIZE_BYTES*8-1:0] i_fill_data,
  input  logic                         i_hit_valid,
  input  logic [SET_IDX_W-1:0]         i_hit_set,
  input  logic [3:0]                   i_hit_way,
  input  logic                         i_flush,
  output logic [3:0]                   o_way_we,
  output logic [SET_IDX_W-1:0]         o_way_set,
  output logic [LINE_SIZE_BYTES*8-1:0] o_way_data,
  output logic                         o_fill_done,
  output logic [3:0]                   o_fill_way
);

  localparam int NUM_SETS = 2**SET_IDX_W;
  localparam int LW       = LINE_SIZE_BYTES*8;

  typedef enum logic {IDLE, WRITE} state_e;

  state_e               state_q;
  logic                 ready_q;
  logic                 done_q;
  logic [3:0]           we_q;
  logic [3:0]           way_q;
  logic [SET_IDX_W-1:0] set_q;
  logic [LW-1:0]        data_q;

  logic [3:0] valid_q [NUM_SETS];
  logic [2:0] plru_q  [NUM_SETS];

  logic [3:0] vld_s;
  logic [2:0] plru_s;
  logic [3:0] victim;
  logic       fill_wr;
  logic       hit_1h;
  logic       hit_en;
  logic [2:0] fill_plru_d;
  logic [2:0] hit_plru_d;

  // Way access points the tree away from the touched way.
  function automatic logic [2:0] plru_touch(
    input logic [2:0] b,
    input logic [3:0] way
  );
    logic [2:0] r;
    r = b;
    case (way)
      4'b0001: begin r[0] = 1'b1; r[1] = 1'b1; end
      4'b0010: begin r[0] = 1'b1; r[1] = 1'b0; end
      4'b0100: begin r[0] = 1'b0; r[2] = 1'b1; end
      4'b1000: begin r[0] = 1'b0; r[2] = 1'b0; end
      default: r = b;
    endcase
    return r;
  endfunction

  assign vld_s  = valid_q[i_fill_set];
  assign plru_s = plru_q[i_fill_set];

  always_comb begin
    victim = 4'b0001;
    if (!vld_s[0])      victim = 4'b0001;
    else if (!vld_s[1]) victim = 4'b0010;
    else if (!vld_s[2]) victim = 4'b0100;
    else if (!vld_s[3]) victim = 4'b1000;
    else if (!plru_s[0])
      victim = plru_s[1] ? 4'b0010 : 4'b0001;
    else
      victim = plru_s[2] ? 4'b1000 : 4'b0100;
  end

  assign fill_wr = (state_q == WRITE);
  assign hit_1h  = (i_hit_way != 4'b0000) &&
                   ((i_hit_way & (i_hit_way - 4'd1)) == 4'b0000);
  // A fill write to the same set wins over the hit.
  assign hit_en  = i_hit_valid && hit_1h &&
                   !(fill_wr && (i_hit_set == set_q));

  assign fill_plru_d = plru_touch(plru_q[set_q], way_q);
  assign hit_plru_d  = plru_touch(plru_q[i_hit_set], i_hit_way);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= 4'b0000;
        plru_q[s]  <= 3'b000;
      end
    end else if (i_flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= 4'b0000;
        plru_q[s]  <= 3'b000;
      end
    end else begin
      if (fill_wr) begin
        valid_q[set_q] <= valid_q[set_q] | way_q;
        plru_q[set_q]  <= fill_plru_d;
      end
      if (hit_en) begin
        plru_q[i_hit_set] <= hit_plru_d;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      we_q    <= 4'b0000;
      way_q   <= 4'b0000;
      set_q   <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_fill_valid && ready_q) begin
            state_q <= WRITE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
            we_q    <= victim;
            way_q   <= victim;
            set_q   <= i_fill_set;
            data_q  <= i_fill_data;
          end
        end
        WRITE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          we_q    <= 4'b0000;
          way_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign o_fill_ready = ready_q;
  assign o_way_we     = we_q;
  assign o_way_set    = set_q;
  assign o_way_data   = data_q;
  assign o_fill_done  = done_q;
  assign o_fill_way   = way_q;

endmodule

// File: tb/tb_cache_way_fill.sv
// Bench for cache_way_fill: a per-set valid/PLRU model is checked every cycle,
// and directed fill sequences are checked against hand-computed victim ways.
module tb_cache_way_fill;

  logic         clk;
  logic         rst;
  logic         fill_valid;
  logic         o_fill_ready;
  logic [5:0]   fill_set;
  logic [511:0] fill_data;
  logic         hit_valid;
  logic [5:0]   hit_set;
  logic [3:0]   hit_way;
  logic         flush;
  logic [3:0]   o_way_we;
  logic [5:0]   o_way_set;
  logic [511:0] o_way_data;
  logic         o_fill_done;
  logic [3:0]   o_fill_way;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  cache_way_fill #(.LINE_SIZE_BYTES(64), .SET_IDX_W(6)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_fill_valid(fill_valid),
    .o_fill_ready(o_fill_ready),
    .i_fill_set  (fill_set),
    .i_fill_data (fill_data),
    .i_hit_valid (hit_valid),
    .i_hit_set   (hit_set),
    .i_hit_way   (hit_way),
    .i_flush     (flush),
    .o_way_we    (o_way_we),
    .o_way_set   (o_way_set),
    .o_way_data  (o_way_data),
    .o_fill_done (o_fill_done),
    .o_fill_way  (o_fill_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] a,
                     input logic [511:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Reference state: valid bit and tree bits per set as plain integers.
  bit           mv [64][4];
  bit           mb [64][3];
  bit           m_busy;
  int           m_set;
  int           m_vic;
  logic [3:0]   e_we, e_way;
  logic         e_done, e_ready;
  logic [5:0]   e_set;
  logic [511:0] e_data;

  function automatic int pick(input int s);
    for (int w = 0; w < 4; w++)
      if (!mv[s][w]) return w;
    if (mb[s][0]) return 2 + int'(mb[s][2]);
    return int'(mb[s][1]);
  endfunction

  task automatic touch(input int s, input int w);
    if (w < 2) begin
      mb[s][0] = 1'b1;
      mb[s][1] = (w == 0);
    end else begin
      mb[s][0] = 1'b0;
      mb[s][2] = (w == 2);
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 64; s++)
      for (int k = 0; k < 4; k++) begin
        mv[s][k] = 1'b0;
        if (k < 3) mb[s][k] = 1'b0;
      end
  endtask

  always @(posedge clk or posedge rst) begin
    bit wr_now, acc, hok;
    int ws, wv, nv, hi;
    if (rst) begin
      m_clear();
      m_busy  = 1'b0;
      e_we    = 4'b0;
      e_way   = 4'b0;
      e_done  = 1'b0;
      e_ready = 1'b1;
      e_set   = 6'd0;
      e_data  = '0;
    end else begin
      wr_now = m_busy;
      ws     = m_set;
      wv     = m_vic;
      acc    = !m_busy && fill_valid;
      nv     = 0;
      if (acc) nv = pick(int'(fill_set));
      hok = hit_valid && ($countones(hit_way) == 1);
      hi  = 0;
      for (int w = 0; w < 4; w++)
        if (hit_way[w]) hi = w;
      if (flush) begin
        m_clear();
      end else begin
        if (wr_now) begin
          mv[ws][wv] = 1'b1;
          touch(ws, wv);
        end
        if (hok && !(wr_now && int'(hit_set) == ws))
          touch(int'(hit_set), hi);
      end
      if (acc) begin
        m_busy  = 1'b1;
        m_set   = int'(fill_set);
        m_vic   = nv;
        e_we    = 4'(1 << nv);
        e_way   = 4'(1 << nv);
        e_done  = 1'b1;
        e_ready = 1'b0;
        e_set   = fill_set;
        e_data  = fill_data;
      end else begin
        m_busy  = 1'b0;
        e_we    = 4'b0;
        e_way   = 4'b0;
        e_done  = 1'b0;
        e_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m ready", {511'd0, o_fill_ready}, {511'd0, e_ready});
      chk("m we", {508'd0, o_way_we}, {508'd0, e_we});
      chk("m done", {511'd0, o_fill_done}, {511'd0, e_done});
      chk("m way", {508'd0, o_fill_way}, {508'd0, e_way});
      if (e_done) begin
        chk("m set", {506'd0, o_way_set}, {506'd0, e_set});
        chk("m data", o_way_data, e_data);
      end
    end
  end

  // Called and returns on a falling edge; holds the request until accepted.
  task automatic do_fill(input logic [5:0] s, input logic [511:0] d,
                         input logic [3:0] ew, input logic whv,
                         input logic [5:0] whs, input logic [3:0] whw,
                         input logic wfl, input string nm);
    int n;
    n = 0;
    fill_valid = 1'b1;
    fill_set   = s;
    fill_data  = d;
    while (!o_fill_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got ready=0 want ready=1", nm);
    end
    @(posedge clk);
    @(negedge clk);
    fill_valid = 1'b0;
    fill_set   = 6'($urandom);
    fill_data  = '0;
    hit_valid  = whv;
    hit_set    = whs;
    hit_way    = whw;
    flush      = wfl;
    chk({nm, " way"}, {508'd0, o_fill_way}, {508'd0, ew});
    chk({nm, " we"}, {508'd0, o_way_we}, {508'd0, ew});
    chk({nm, " ready"}, {511'd0, o_fill_ready}, 512'd0);
    chk({nm, " data"}, o_way_data, d);
    @(negedge clk);
    hit_valid = 1'b0;
    hit_way   = 4'b0;
    flush     = 1'b0;
  endtask

  task automatic do_hit(input logic [5:0] s, input logic [3:0] w);
    hit_valid = 1'b1;
    hit_set   = s;
    hit_way   = w;
    @(negedge clk);
    hit_valid = 1'b0;
    hit_way   = 4'b0;
  endtask

  function automatic logic [511:0] pat(input logic [31:0] w);
    return {16{w}};
  endfunction

  initial begin
    fill_valid = 1'b0;
    fill_set   = 6'd0;
    fill_data  = '0;
    hit_valid  = 1'b0;
    hit_set    = 6'd0;
    hit_way    = 4'b0;
    flush      = 1'b0;
    rst        = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst ready", {511'd0, o_fill_ready}, 512'd1);
    chk("rst we", {508'd0, o_way_we}, 512'd0);
    chk("rst done", {511'd0, o_fill_done}, 512'd0);
    chk("rst way", {508'd0, o_fill_way}, 512'd0);
    chk("rst set", {506'd0, o_way_set}, 512'd0);
    chk("rst data", o_way_data, 512'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    do_fill(6'd5, pat(32'hAAAA_0001), 4'b0001, 0, 0, 0, 0, "s5 A");
    do_fill(6'd5, pat(32'hBBBB_0002), 4'b0010, 0, 0, 0, 0, "s5 B");
    do_fill(6'd5, pat(32'hCCCC_0003), 4'b0100, 0, 0, 0, 0, "s5 C");
    do_fill(6'd5, pat(32'hDDDD_0004), 4'b1000, 0, 0, 0, 0, "s5 D");
    // b0=0 points at the left pair, b1=0 at way0.
    do_fill(6'd5, pat(32'hEEEE_0005), 4'b0001, 0, 0, 0, 0, "s5 E");
    do_hit(6'd5, 4'b0001);
    do_hit(6'd5, 4'b0010);
    do_hit(6'd5, 4'b0100);
    do_hit(6'd5, 4'b1000);
    do_hit(6'd5, 4'b0100);
    do_fill(6'd5, pat(32'h1234_5678), 4'b0001, 0, 0, 0, 0, "s5 hits");

    hit_valid = 1'b1;
    hit_set   = 6'd7;
    hit_way   = 4'b0011;
    do_fill(6'd7, pat(32'h7777_0007), 4'b0001, 0, 0, 0, 0, "s7 multihit");

    do_fill(6'd4, pat(32'h4444_0000), 4'b0001, 0, 0, 0, 0, "s4 f0");
    do_fill(6'd4, pat(32'h4444_0001), 4'b0010, 0, 0, 0, 0, "s4 f1");
    do_fill(6'd4, pat(32'h4444_0002), 4'b0100, 0, 0, 0, 0, "s4 f2");
    do_fill(6'd4, pat(32'h4444_0003), 4'b1000, 0, 0, 0, 0, "s4 f3");
    do_hit(6'd4, 4'b0001);
    do_fill(6'd3, pat(32'h3333_0000), 4'b0001, 0, 0, 0, 0, "s3 f0");
    do_fill(6'd3, pat(32'h3333_0001), 4'b0010, 0, 0, 0, 0, "s3 f1");
    do_fill(6'd3, pat(32'h3333_0002), 4'b0100, 0, 0, 0, 0, "s3 f2");
    do_fill(6'd3, pat(32'h3333_0003), 4'b1000, 1, 6'd3, 4'b0001, 0,
            "s3 f3 samehit");
    do_fill(6'd10, pat(32'hAAAA_000A), 4'b0001, 1, 6'd4, 4'b1000, 0,
            "s10 hit s4");
    do_fill(6'd3, pat(32'h3333_0004), 4'b0001, 0, 0, 0, 0, "s3 victim");
    do_fill(6'd4, pat(32'h4444_0004), 4'b0010, 0, 0, 0, 0, "s4 victim");

    do_fill(6'd9, pat(32'h9999_0000), 4'b0001, 0, 0, 0, 0, "s9 f0");
    do_fill(6'd9, pat(32'h9999_0001), 4'b0010, 0, 0, 0, 1'b1, "s9 flush");
    do_fill(6'd9, pat(32'h9999_0002), 4'b0001, 0, 0, 0, 0, "s9 post0");
    do_fill(6'd9, pat(32'h9999_0003), 4'b0010, 0, 0, 0, 0, "s9 post1");

    chk_en     = 1'b0;
    fill_valid = 1'b1;
    fill_set   = 6'd9;
    fill_data  = pat(32'hDEAD_BEEF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst we", {508'd0, o_way_we}, 512'd0);
    chk("arst done", {511'd0, o_fill_done}, 512'd0);
    chk("arst ready", {511'd0, o_fill_ready}, 512'd1);
    @(negedge clk);
    fill_valid = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    do_fill(6'd9, pat(32'h0BAD_F00D), 4'b0001, 0, 0, 0, 0, "post rst");

    for (int c = 0; c < 2000; c++) begin
      fill_valid = 1'($urandom_range(0, 1));
      fill_set   = 6'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++)
        fill_data[i*32 +: 32] = $urandom;
      hit_valid = 1'($urandom_range(0, 1));
      hit_set   = 6'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        hit_way = 4'($urandom_range(0, 15));
      else
        hit_way = 4'(1 << $urandom_range(0, 3));
      flush = ($urandom_range(0, 80) == 0);
      @(negedge clk);
    end
    fill_valid = 1'b0;
    hit_valid  = 1'b0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
